// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller driving one shared seven-segment decoder across NDIG digits.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int NDIG = 8,
  parameter int DIV  = 1000,
  parameter int IW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [4*NDIG-1:0] load_data,
  output logic              load_ready,
  input  logic [NDIG-1:0]   dig_mask,
  output logic [3:0]        nib_out,
  output logic              nib_en,
  output logic [NDIG-1:0]   dig_sel,
  output logic              frame_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]     pcnt_reg;
  logic [IW-1:0]     idx_reg;
  logic [IW-1:0]     idx_next;
  logic [4*NDIG-1:0] disp_reg;
  logic [4*NDIG-1:0] pend_reg;
  logic [4*NDIG-1:0] disp_next;
  logic              pend_valid_reg;
  logic [3:0]        nib_reg;
  logic              en_reg;
  logic [NDIG-1:0]   sel_reg;
  logic              frame_tick_reg;

  logic              tick;
  logic              wrap;
  logic              commit;
  logic              xfer;
  logic [NDIG-1:0]   sel_next;
  logic [NDIG-1:0]   lzb_keep;
  logic [3:0]        nib_next;
  logic              en_next;

  assign tick      = (pcnt_reg == PW'(DIV - 1));
  assign wrap      = tick && (idx_reg == IW'(NDIG - 1));
  assign idx_next  = !tick ? idx_reg : (wrap ? '0 : idx_reg + IW'(1));
  // xfer and commit are mutually exclusive: xfer needs an empty slot, commit a full one
  assign commit    = wrap && pend_valid_reg;
  assign xfer      = load_valid && !pend_valid_reg;
  assign disp_next = commit ? pend_reg : disp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      assign sel_next[gi] = (idx_next != IW'(gi));
`ifdef SEG_LZB_EN
      if (gi == 0) begin : g_first
        assign lzb_keep[gi] = 1'b1;
      end else begin : g_upper
        // blank when this digit and every more significant one are zero
        assign lzb_keep[gi] = |disp_next[4*NDIG-1:4*gi];
      end
`else
      assign lzb_keep[gi] = 1'b1;
`endif
    end
  endgenerate

  always_comb begin
    nib_next = 4'h0;
    en_next  = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_next == IW'(k)) begin
        nib_next = disp_next[4*k +: 4];
        en_next  = dig_mask[k] & lzb_keep[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg       <= '0;
      idx_reg        <= IW'(NDIG - 1);
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      nib_reg        <= 4'h0;
      en_reg         <= 1'b0;
      sel_reg        <= '1;
      frame_tick_reg <= 1'b0;
    end else begin
      pcnt_reg       <= tick ? '0 : pcnt_reg + PW'(1);
      idx_reg        <= idx_next;
      disp_reg       <= disp_next;
      frame_tick_reg <= wrap;
      if (xfer) begin
        pend_reg       <= load_data;
        pend_valid_reg <= 1'b1;
      end else if (commit) begin
        pend_valid_reg <= 1'b0;
      end
      if (tick) begin
        sel_reg <= sel_next;
        nib_reg <= nib_next;
        en_reg  <= en_next;
      end
    end
  end

  assign load_ready = ~pend_valid_reg;
  assign nib_out    = nib_reg;
  assign nib_en     = en_reg;
  assign dig_sel    = sel_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller that time-multiplexes one shared bcd7seg decoder across NDIG seven-segment digits.
- Holds the displayed hex value in a display register, and accepts new values through a valid/ready handshake.
- Applies new values only at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between value producers (keyboard/ASCII path, counters) and the decoder: drives its b/en inputs plus the active-low digit selects.

Parameters:
- NDIG, 8, number of digits scanned (legal 1..16).
- DIV, 1000, clk cycles per digit slot (legal >=1).
- IW, 4, width of digit index (must satisfy 2**IW >= NDIG).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  producer offers load_data
- load_data  in  4*NDIG  new value; nibble k (bits 4k+3:4k) is digit k, digit 0 least significant
- load_ready  out  1  controller can accept a value this cycle
- dig_mask  in  NDIG  per-digit enable; 0 blanks that digit
- nib_out  out  4  nibble for the shared decoder's b input
- nib_en  out  1  decoder en input
- dig_sel  out  NDIG  active-low one-hot digit select
- frame_tick  out  1  one-cycle pulse when digit 0 becomes selected

Behaviour:
- Reset (rst=1 at an edge):
  - Internal state: pcnt=0, idx=NDIG-1, disp=0, pend=0, pend_valid=0.
  - Outputs: nib_out=0, nib_en=0, dig_sel=all ones (all digits off), frame_tick=0.
  - rst overrides everything, including an in-flight handshake; a pending value is discarded.
- Prescaler:
  - pcnt counts 0..DIV-1 and wraps.
  - tick = (pcnt==DIV-1). With DIV=1, tick fires every cycle.
- Digit advance, on a tick edge:
  - idx <= (idx==NDIG-1) ? 0 : idx+1.
  - The first tick after reset therefore selects digit 0.
- Registered outputs, updated only on tick edges using the new idx value n:
  - dig_sel <= ~(1<<n).
  - nib_out <= disp_next[4n+3:4n].
  - nib_en <= dig_mask[n], further qualified by the optional feature.
  - Between ticks these outputs hold their values.
- frame_tick:
  - 1 for exactly the cycle after a tick edge where idx wrapped to 0; otherwise 0.
  - With NDIG=1, every tick wraps.
- Handshake:
  - load_ready = ~pend_valid (combinational).
  - Transfer occurs when load_valid && load_ready at an edge: pend <= load_data, pend_valid <= 1.
  - load_data need not be held after the transfer.
- Commit:
  - On a wrapping tick edge with pend_valid=1: disp <= pend, pend_valid <= 0.
  - disp_next is pend in that case, otherwise disp. Digit 0 of the new frame already shows the new value.
- Simultaneous transfer and wrap on the same edge:
  - The value goes to pend only.
  - It is committed at the next wrap, one full frame later.
- Back-pressure:
  - A second value offered while pend_valid=1 waits (load_ready=0).
  - Worst-case acceptance latency is NDIG*DIV cycles.
- dig_mask is sampled only at tick edges. A change mid-slot takes effect at the next slot.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- When defined:
  - For digit k>0, nib_en is forced 0 if nibbles k..NDIG-1 of disp_next are all zero.
  - Digit 0 is never blanked by this rule. dig_mask still applies (AND).
  - dig_sel is unchanged; blanking is done via nib_en only.
- When undefined: nib_en = dig_mask[n] only.

Test Plan (NDIG=4, DIV=3 unless noted):
- Reset, then idle, dig_mask=4'hF:
  - First tick at cycle 3 after reset release: dig_sel=4'b1110, nib_out=0, nib_en=1, frame_tick=1 for one cycle.
  - dig_sel then rotates 1101, 1011, 0111, 1110, with 3-cycle slots.
- Load 16'hA3F0 mid-frame:
  - load_ready drops the cycle after the transfer.
  - Remaining slots of the current frame still show 0.
  - Next frame shows nib_out 0, F, 3, A.
  - load_ready returns to 1 after the wrap edge.
- Transfer on the same edge as a wrap:
  - That frame still shows the old value.
  - The new value appears one frame later.
- Second load_valid held while pending:
  - load_ready=0 until the commit.
  - Then the second value is accepted and shown the following frame.
- dig_mask=4'b1010:
  - nib_en=0 in slots 0 and 2, 1 in slots 1 and 3.
  - dig_sel is unaffected.
  - With SEG_LZB_EN defined and value 16'h0005: nib_en = 1, 0, 0, 0 (dig_mask=F).
- DIV=1, NDIG=1 corner, plus rst asserted mid-pending:
  - DIV=1, NDIG=1: frame_tick is high every cycle and dig_sel stays 0.
  - rst mid-pending: pend is dropped, outputs return to reset values, and disp=0 after restart.
